// File: rtl/game_pkg.sv
// game_pkg: types and widths shared by the phase controller and the enemy
// phase logic.
//   state_e  - game state codes as they appear on the state bus
//   HP_W     - width of the player and enemy hit-point registers
//   TURN_W   - width of the enemy pattern index
//   PHASE_W  - width of the phase counter
//   sat_sub  - hit-point subtraction that stops at zero
package game_pkg;

    localparam int HP_W    = 8;
    localparam int TURN_W  = 4;
    localparam int DMG_W   = 4;
    localparam int PHASE_W = 32;

    // The enemy block detects the start of its phase by watching for the
    // transition into ST_ENEMY, so these codes are part of the interface.
    typedef enum logic [3:0] {
        ST_TITLE    = 4'b1010,
        ST_MENU     = 4'b0001,
        ST_ATTACK   = 4'b0010,
        ST_ENEMY    = 4'b1000,
        ST_GAMEOVER = 4'b1100,
        ST_WIN      = 4'b1111
    } state_e;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                 input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: free-running phase counter with synchronous clear.
//   clk, rst  - clock and synchronous active-high reset
//   clr_i     - restart the count from zero on the next edge
//   limit_i   - phase length in cycles
//   tc_o      - high while the count equals limit_i-1
//   count_o   - current count
module phase_timer
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic [PHASE_W-1:0] limit_i,
    output logic               tc_o,
    output logic [PHASE_W-1:0] count_o
);

    logic [PHASE_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clr_i) count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign tc_o    = (count_q == limit_i - 1'b1);
    assign count_o = count_q;

endmodule

// File: rtl/phase_controller.sv
// phase_controller: turn-based game sequencer. Walks TITLE -> MENU ->
// ATTACK -> ENEMY and back, tracks hit points and the enemy pattern
// index, and ends the game in WIN or GAMEOVER.
//   clk, rst        - clock and synchronous active-high reset
//   start_in        - starts a game from TITLE, GAMEOVER or WIN
//   confirm_in      - menu select / attack stop
//   damage_in       - player damage, taken with confirm_in in ATTACK
//   busy_in         - enemy phase busy flag (observed only)
//   finished_in     - enemy phase complete
//   hit_in          - arrow reached the heart
//   state_out       - current state code
//   turn_out        - current / next enemy pattern index
//   player_hp_out   - player hit points
//   enemy_hp_out    - enemy hit points
//   timeout_out     - sticky: an enemy phase hit its watchdog limit
module phase_controller
    import game_pkg::*;
#(
    parameter int unsigned PLAYER_HP     = 20,
    parameter int unsigned ENEMY_HP      = 40,
    parameter int unsigned MAX_TURN      = 8,
    parameter int unsigned ATTACK_CYCLES = 130_000_000,
    parameter int unsigned PHASE_TIMEOUT = 650_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              confirm_in,
    input  logic [DMG_W-1:0]  damage_in,
    input  logic              busy_in,
    input  logic              finished_in,
    input  logic              hit_in,
    output logic [3:0]        state_out,
    output logic [TURN_W-1:0] turn_out,
    output logic [HP_W-1:0]   player_hp_out,
    output logic [HP_W-1:0]   enemy_hp_out,
    output logic              timeout_out
);

    state_e              state_q, state_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic [HP_W-1:0]     php_q, php_d;
    logic [HP_W-1:0]     ehp_q, ehp_d;
    logic                timeout_q, timeout_d;

    logic                tmr_clr;
    logic                tmr_tc;
    logic [PHASE_W-1:0]  tmr_limit;
    logic [PHASE_W-1:0]  tmr_count;

    // Only ATTACK and ENEMY are bounded; the counter also runs in other
    // states but its terminal count is ignored there.
    assign tmr_limit = (state_q == ST_ATTACK) ? PHASE_W'(ATTACK_CYCLES)
                                              : PHASE_W'(PHASE_TIMEOUT);
    assign tmr_clr   = (state_d != state_q);

    phase_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tmr_clr),
        .limit_i (tmr_limit),
        .tc_o    (tmr_tc),
        .count_o (tmr_count)
    );

    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        php_d     = php_q;
        ehp_d     = ehp_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_TITLE, ST_GAMEOVER, ST_WIN: begin
                if (start_in) begin
                    php_d     = HP_W'(PLAYER_HP);
                    ehp_d     = HP_W'(ENEMY_HP);
                    turn_d    = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_MENU;
                end
            end

            ST_MENU: begin
                if (confirm_in) state_d = ST_ATTACK;
            end

            ST_ATTACK: begin
                // An expired attack window counts as a zero-damage stop.
                if (confirm_in || tmr_tc) begin
                    if (confirm_in) ehp_d = sat_sub(ehp_q, HP_W'(damage_in));
                    state_d = (ehp_d == '0) ? ST_WIN : ST_ENEMY;
                end
            end

            ST_ENEMY: begin
                if (hit_in) php_d = sat_sub(php_q, HP_W'(1));
                // Death wins over a same-cycle phase end; the turn is not
                // credited in that case.
                if (hit_in && php_d == '0) begin
                    state_d = ST_GAMEOVER;
                end else if (finished_in || tmr_tc) begin
                    turn_d = turn_q + 1'b1;
                    if (tmr_tc) timeout_d = 1'b1;
                    state_d = (turn_d == TURN_W'(MAX_TURN)) ? ST_WIN : ST_MENU;
                end
            end

            default: state_d = ST_TITLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_TITLE;
            turn_q    <= '0;
            php_q     <= HP_W'(PLAYER_HP);
            ehp_q     <= HP_W'(ENEMY_HP);
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            php_q     <= php_d;
            ehp_q     <= ehp_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_out     = state_q;
    assign turn_out      = turn_q;
    assign player_hp_out = php_q;
    assign enemy_hp_out  = ehp_q;
    assign timeout_out   = timeout_q;

    // busy_in never steers the FSM. The enemy block is expected to raise it
    // within two cycles of entering ENEMY; this is tracked for coverage.
    logic [1:0] enemy_age_q, enemy_age_d;
    logic       busy_prev_q;

    always_comb begin
        enemy_age_d = enemy_age_q;
        if (state_d == ST_ENEMY && state_q != ST_ENEMY) enemy_age_d = '0;
        else if (state_q == ST_ENEMY && enemy_age_q != 2'd3) enemy_age_d = enemy_age_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enemy_age_q <= 2'd3;
            busy_prev_q <= 1'b0;
        end else begin
            enemy_age_q <= enemy_age_d;
            busy_prev_q <= busy_in;
        end
    end

    cover property (@(posedge clk) disable iff (rst)
        (state_q == ST_ENEMY) && busy_in && !busy_prev_q && (enemy_age_q <= 2'd2));

    logic unused_count;
    assign unused_count = ^tmr_count;

    cover property (@(posedge clk) disable iff (rst) unused_count);

endmodule

// File: tb/tb_phase_controller.sv
module tb_phase_controller;

    localparam logic [3:0] S_TITLE = 4'b1010;
    localparam logic [3:0] S_MENU  = 4'b0001;
    localparam logic [3:0] S_ATK   = 4'b0010;
    localparam logic [3:0] S_ENEMY = 4'b1000;
    localparam logic [3:0] S_OVER  = 4'b1100;
    localparam logic [3:0] S_WIN   = 4'b1111;

    logic       clk = 1'b0;
    logic       rst, start_in, confirm_in, busy_in, finished_in, hit_in;
    logic [3:0] damage_in;
    logic [3:0] state_out, turn_out;
    logic [7:0] player_hp_out, enemy_hp_out;
    logic       timeout_out;

    // second instance with a tiny enemy for the one-hit kill case
    logic       start2, confirm2;
    logic [3:0] damage2;
    logic [3:0] state2, turn2;
    logic [7:0] php2, ehp2;
    logic       tmo2;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    phase_controller #(.PLAYER_HP(20), .ENEMY_HP(40), .MAX_TURN(8),
                       .ATTACK_CYCLES(50), .PHASE_TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .confirm_in(confirm_in),
        .damage_in(damage_in), .busy_in(busy_in), .finished_in(finished_in),
        .hit_in(hit_in), .state_out(state_out), .turn_out(turn_out),
        .player_hp_out(player_hp_out), .enemy_hp_out(enemy_hp_out),
        .timeout_out(timeout_out)
    );

    phase_controller #(.PLAYER_HP(20), .ENEMY_HP(3), .MAX_TURN(8),
                       .ATTACK_CYCLES(50), .PHASE_TIMEOUT(100)) dut2 (
        .clk(clk), .rst(rst), .start_in(start2), .confirm_in(confirm2),
        .damage_in(damage2), .busy_in(1'b0), .finished_in(1'b0),
        .hit_in(1'b0), .state_out(state2), .turn_out(turn2),
        .player_hp_out(php2), .enemy_hp_out(ehp2), .timeout_out(tmo2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();   start_in = 1;    tick(); start_in = 0;    endtask
    task automatic pulse_confirm(input logic [3:0] d);
        damage_in = d; confirm_in = 1; tick(); confirm_in = 0; damage_in = 0;
    endtask
    task automatic pulse_hit();      hit_in = 1;      tick(); hit_in = 0;      endtask
    task automatic pulse_finished(); finished_in = 1; tick(); finished_in = 0; endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        cmp_cnt++; if (state_out !== S_TITLE) begin err_cnt++; $display("FAIL reset_state got %h exp %h", state_out, S_TITLE); end
        cmp_cnt++; if (turn_out !== 4'd0) begin err_cnt++; $display("FAIL reset_turn got %0d exp 0", turn_out); end
        cmp_cnt++; if (player_hp_out !== 8'd20) begin err_cnt++; $display("FAIL reset_php got %0d exp 20", player_hp_out); end
        cmp_cnt++; if (enemy_hp_out !== 8'd40) begin err_cnt++; $display("FAIL reset_ehp got %0d exp 40", enemy_hp_out); end
        cmp_cnt++; if (timeout_out !== 1'b0) begin err_cnt++; $display("FAIL reset_timeout got %b exp 0", timeout_out); end
        cmp_cnt++; if (ehp2 !== 8'd3) begin err_cnt++; $display("FAIL reset_ehp2 got %0d exp 3", ehp2); end
    endtask

    task automatic test_start_sequence();
        pulse_confirm(4'd9);   // ignored in TITLE
        cmp_cnt++; if (state_out !== S_TITLE) begin err_cnt++; $display("FAIL title_confirm got %h exp %h", state_out, S_TITLE); end
        pulse_start();
        cmp_cnt++; if (state_out !== S_MENU) begin err_cnt++; $display("FAIL start_menu got %h exp %h", state_out, S_MENU); end
        // start, hit and finished are all ignored in MENU
        pulse_start(); pulse_hit(); pulse_finished();
        cmp_cnt++; if (state_out !== S_MENU) begin err_cnt++; $display("FAIL menu_ignore got %h exp %h", state_out, S_MENU); end
        cmp_cnt++; if (player_hp_out !== 8'd20 || turn_out !== 4'd0) begin err_cnt++; $display("FAIL menu_ignore_hp got php %0d turn %0d exp 20 0", player_hp_out, turn_out); end
        pulse_confirm(4'd0);
        cmp_cnt++; if (state_out !== S_ATK) begin err_cnt++; $display("FAIL menu_attack got %h exp %h", state_out, S_ATK); end
        pulse_confirm(4'd5);
        cmp_cnt++; if (state_out !== S_ENEMY) begin err_cnt++; $display("FAIL attack_enemy got %h exp %h", state_out, S_ENEMY); end
        cmp_cnt++; if (enemy_hp_out !== 8'd35) begin err_cnt++; $display("FAIL attack_dmg got %0d exp 35", enemy_hp_out); end
    endtask

    task automatic test_rounds();
        pulse_confirm(4'd7);   // ignored in ENEMY
        cmp_cnt++; if (state_out !== S_ENEMY || enemy_hp_out !== 8'd35) begin err_cnt++; $display("FAIL enemy_confirm got %h/%0d exp %h/35", state_out, enemy_hp_out, S_ENEMY); end
        pulse_hit();
        cmp_cnt++; if (player_hp_out !== 8'd19 || state_out !== S_ENEMY) begin err_cnt++; $display("FAIL enemy_hit got %0d/%h exp 19/%h", player_hp_out, state_out, S_ENEMY); end
        pulse_finished();
        cmp_cnt++; if (turn_out !== 4'd1 || state_out !== S_MENU) begin err_cnt++; $display("FAIL round1 got turn %0d st %h exp 1 %h", turn_out, state_out, S_MENU); end
        for (int r = 1; r < 8; r++) begin
            pulse_confirm(4'd0);
            pulse_confirm(4'd1);
            cmp_cnt++; if (state_out !== S_ENEMY) begin err_cnt++; $display("FAIL round%0d_enemy got %h exp %h", r + 1, state_out, S_ENEMY); end
            pulse_finished();
            cmp_cnt++;
            if (turn_out !== 4'(r + 1) || state_out !== ((r == 7) ? S_WIN : S_MENU)) begin
                err_cnt++; $display("FAIL round%0d_end got turn %0d st %h exp turn %0d", r + 1, turn_out, state_out, r + 1);
            end
        end
        cmp_cnt++; if (enemy_hp_out !== 8'd28) begin err_cnt++; $display("FAIL rounds_ehp got %0d exp 28", enemy_hp_out); end
    endtask

    task automatic test_gameover();
        pulse_start();
        cmp_cnt++; if (state_out !== S_MENU || turn_out !== 4'd0 || player_hp_out !== 8'd20 || enemy_hp_out !== 8'd40) begin
            err_cnt++; $display("FAIL win_restart got st %h turn %0d php %0d ehp %0d exp %h 0 20 40", state_out, turn_out, player_hp_out, enemy_hp_out, S_MENU);
        end
        pulse_confirm(4'd0);
        pulse_confirm(4'd0);
        for (int i = 0; i < 19; i++) pulse_hit();
        cmp_cnt++; if (player_hp_out !== 8'd1 || state_out !== S_ENEMY) begin err_cnt++; $display("FAIL hp_one got %0d/%h exp 1/%h", player_hp_out, state_out, S_ENEMY); end
        hit_in = 1; finished_in = 1; tick(); hit_in = 0; finished_in = 0;
        cmp_cnt++; if (state_out !== S_OVER) begin err_cnt++; $display("FAIL gameover_state got %h exp %h", state_out, S_OVER); end
        cmp_cnt++; if (player_hp_out !== 8'd0 || turn_out !== 4'd0) begin err_cnt++; $display("FAIL gameover_hp got php %0d turn %0d exp 0 0", player_hp_out, turn_out); end
        pulse_confirm(4'd0);   // ignored in GAMEOVER
        cmp_cnt++; if (state_out !== S_OVER) begin err_cnt++; $display("FAIL over_confirm got %h exp %h", state_out, S_OVER); end
    endtask

    task automatic test_attack_timeout();
        pulse_start();
        pulse_confirm(4'd0);
        for (int i = 0; i < 49; i++) tick();
        cmp_cnt++; if (state_out !== S_ATK) begin err_cnt++; $display("FAIL attack_window_49 got %h exp %h", state_out, S_ATK); end
        tick();
        cmp_cnt++; if (state_out !== S_ENEMY || enemy_hp_out !== 8'd40) begin err_cnt++; $display("FAIL attack_window_50 got %h/%0d exp %h/40", state_out, enemy_hp_out, S_ENEMY); end
    endtask

    task automatic test_phase_timeout();
        // now one cycle into ENEMY; busy toggles must not matter
        busy_in = 1; tick(); busy_in = 0;
        for (int i = 0; i < 98; i++) tick();
        cmp_cnt++; if (state_out !== S_ENEMY || timeout_out !== 1'b0) begin err_cnt++; $display("FAIL phase_99 got %h/%b exp %h/0", state_out, timeout_out, S_ENEMY); end
        tick();
        cmp_cnt++; if (state_out !== S_MENU || timeout_out !== 1'b1) begin err_cnt++; $display("FAIL phase_100 got %h/%b exp %h/1", state_out, timeout_out, S_MENU); end
        cmp_cnt++; if (turn_out !== 4'd1) begin err_cnt++; $display("FAIL phase_turn got %0d exp 1", turn_out); end
    endtask

    task automatic test_enemy_win();
        start2 = 1; tick(); start2 = 0;
        confirm2 = 1; tick(); confirm2 = 0;
        cmp_cnt++; if (state2 !== S_ATK) begin err_cnt++; $display("FAIL kill_attack got %h exp %h", state2, S_ATK); end
        damage2 = 4'd15; confirm2 = 1; tick(); confirm2 = 0; damage2 = 0;
        cmp_cnt++; if (state2 !== S_WIN || ehp2 !== 8'd0) begin err_cnt++; $display("FAIL kill_win got %h/%0d exp %h/0", state2, ehp2, S_WIN); end
    endtask

    task automatic test_reset_mid();
        pulse_confirm(4'd0);
        pulse_confirm(4'd0);
        pulse_hit();
        cmp_cnt++; if (state_out !== S_ENEMY || player_hp_out !== 8'd19) begin err_cnt++; $display("FAIL pre_reset got %h/%0d exp %h/19", state_out, player_hp_out, S_ENEMY); end
        rst = 1; hit_in = 1; finished_in = 1; tick(); rst = 0; hit_in = 0; finished_in = 0;
        cmp_cnt++; if (state_out !== S_TITLE || player_hp_out !== 8'd20) begin err_cnt++; $display("FAIL mid_reset got %h/%0d exp %h/20", state_out, player_hp_out, S_TITLE); end
        cmp_cnt++; if (turn_out !== 4'd0 || timeout_out !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_turn got %0d/%b exp 0/0", turn_out, timeout_out); end
    endtask

    initial begin
        rst = 1; start_in = 0; confirm_in = 0; damage_in = 0; busy_in = 0;
        finished_in = 0; hit_in = 0; start2 = 0; confirm2 = 0; damage2 = 0;
        test_reset();
        test_start_sequence();
        test_rounds();
        test_gameover();
        test_attack_timeout();
        test_phase_timeout();
        test_enemy_win();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
